id_insn_buffer: RTL
===================

ID_INSN_BUFFER -- requirements
Module: id_insn_buffer

Interface
REQ-001 SHALL take parameter WORD_ADDR_W, default 30, instruction word-address width.
REQ-002 SHALL take parameter WORD_DATA_W, default 32, instruction width.
REQ-003 SHALL take parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-004 SHALL take parameter BYPASS, default 0; 1 enables empty-buffer pass-through.
REQ-005 SHALL have one clock and an asynchronous, active-low reset, named as the codebase does: clk  in  1  rising-edge clock.
REQ-006 reset_  in  1  asynchronous active-low reset.
REQ-007 IFEn  in  1  IF stage holds a valid instruction.
REQ-008 IFPC  in  WORD_ADDR_W  PC of the IF instruction.
REQ-009 IFInsn  in  WORD_DATA_W  IF instruction word.
REQ-010 IFReady  out  1  buffer accepts the IF instruction this cycle.
REQ-011 DecAccept  in  1  decoder consumes the head entry this cycle.
REQ-012 Stall  in  1  pipeline stall; blocks pop.
REQ-013 LDHazard  in  1  load-use interlock; blocks pop.
REQ-014 BrTaken  in  1  decoder resolved a taken branch on the head entry.
REQ-015 Flush  in  1  pipeline flush; empties buffer.
REQ-016 BufEn  out  1  head entry valid.
REQ-017 BufPC  out  WORD_ADDR_W  head PC.
REQ-018 BufInsn  out  WORD_DATA_W  head instruction.
REQ-019 BufCount  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-020 Push SHALL occur when IFEn && IFReady && !Flush && !(Pop && BrTaken).
REQ-021 IFReady SHALL equal (BufCount != DEPTH), from registered state only; no push into a full buffer even with same-cycle pop.
REQ-022 Pop SHALL occur when BufEn && DecAccept && !Stall && !LDHazard && !Flush.
REQ-023 BufEn SHALL be 1 when BufCount != 0; BufPC/BufInsn SHALL present the entry at the read pointer.
REQ-024 With BYPASS=0, a push into an empty buffer SHALL be visible on BufEn the next cycle (latency 1).
REQ-025 With BYPASS=1 and BufCount==0, BufEn/BufPC/BufInsn SHALL mirror IFEn/IFPC/IFInsn combinationally; a same-cycle pop SHALL consume it without storing it, leaving BufCount 0.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; BufCount SHALL track push minus pop, never exceeding DEPTH or underflowing.
REQ-027 Simultaneous push and pop SHALL leave BufCount unchanged and advance both pointers.
REQ-028 Pop with BrTaken SHALL consume the head, discard all younger entries and any same-cycle push; next cycle BufCount=0 and pointers equal.
REQ-029 BrTaken without Pop SHALL be ignored.
REQ-030 Flush SHALL override every other input: next cycle BufCount=0, pointers 0, no push, no pop.
REQ-031 Stall or LDHazard SHALL hold the head stable for its duration while pushes continue until full.
REQ-032 Storage contents of empty entries are don't-care; BufPC/BufInsn are don't-care while BufEn=0 except as REQ-034 defines.

Reset
REQ-033 Asserting reset_ low SHALL immediately clear pointers and BufCount to 0, regardless of clk, including mid-push/pop.
REQ-034 During and after reset: BufEn=0, BufCount=0, IFReady=1, BufPC=0, BufInsn=0 (BYPASS=0); storage array need not be reset.

Structure
REQ-035 Width defaults and ID_BUF_DEPTH default SHALL live in the shared cpu.vh header; no local width literals.
REQ-036 Storage SHALL be one sub-module id_buf_mem: DEPTH x (WORD_ADDR_W+WORD_DATA_W), one write port, one asynchronous read port.
REQ-037 Pointer/count control SHALL reside in id_insn_buffer; total RTL 120-400 lines.

Verification (DEPTH=4)
REQ-038 Reset, push PCs 0x10..0x13 with DecAccept=0 -> BufCount 1,2,3,4; IFReady=0 after fourth; fifth IFEn ignored.
REQ-039 Full buffer, DecAccept=1 for 6 cycles with IFEn streaming 0x14.. -> heads 0x10,0x11,0x12,0x13,0x14,0x15 in order; pointer wrap verified.
REQ-040 Count=3, LDHazard=1 for 2 cycles with DecAccept=1 -> head 0x10 held, BufCount 3->4, no pop.
REQ-041 Count=3 head 0x20, DecAccept=1, BrTaken=1, IFEn=1 -> next cycle BufCount=0, BufEn=0; pushed word discarded.
REQ-042 Count=2, Flush=1 with IFEn=1 and DecAccept=1 -> next cycle BufCount=0, IFReady=1; reset_ pulsed low mid-stream -> outputs clear immediately.
REQ-043 BYPASS=1, empty, IFEn=1 PC 0x40, DecAccept=1 -> BufEn=1, BufPC=0x40 same cycle; BufCount stays 0.

Source files
------------

// File: rtl/id_insn_buffer_pkg.sv
// Shared constants and types for the decode-stage instruction buffer.
package id_insn_buffer_pkg;

    // Default geometry of the buffer and of the instruction words it holds.
    localparam int ID_WORD_ADDR_W = 30;
    localparam int ID_WORD_DATA_W = 32;
    localparam int ID_BUF_DEPTH   = 4;

    // What the storage does this cycle: write at the tail, read-advance at the head, or both.
    typedef enum logic [1:0] {
        BUF_OP_IDLE = 2'b00,
        BUF_OP_PUSH = 2'b01,
        BUF_OP_POP  = 2'b10,
        BUF_OP_BOTH = 2'b11
    } buf_op_e;

endpackage

// File: rtl/id_buf_mem.sv
// Entry storage for the instruction buffer: one write port, one asynchronous read port.
module id_buf_mem #(
    parameter int DEPTH  = 4,
    parameter int WIDTH  = 62,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents are never reset; only occupied entries are ever read out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/id_insn_buffer.sv
// Decode-stage instruction buffer: FIFO between IF and the decoder with
// branch-discard, flush, interlock hold and optional empty-buffer bypass.
module id_insn_buffer
    import id_insn_buffer_pkg::*;
#(
    parameter int WORD_ADDR_W = ID_WORD_ADDR_W,
    parameter int WORD_DATA_W = ID_WORD_DATA_W,
    parameter int DEPTH       = ID_BUF_DEPTH,
    parameter int BYPASS      = 0
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       IFEn,
    input  logic [WORD_ADDR_W-1:0]     IFPC,
    input  logic [WORD_DATA_W-1:0]     IFInsn,
    output logic                       IFReady,
    input  logic                       DecAccept,
    input  logic                       Stall,
    input  logic                       LDHazard,
    input  logic                       BrTaken,
    input  logic                       Flush,
    output logic                       BufEn,
    output logic [WORD_ADDR_W-1:0]     BufPC,
    output logic [WORD_DATA_W-1:0]     BufInsn,
    output logic [$clog2(DEPTH+1)-1:0] BufCount
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = WORD_ADDR_W + WORD_DATA_W;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             buf_empty;
    logic             bypass_act;
    logic             pop;
    logic             push;
    logic             wr_en;
    logic             rd_adv;
    buf_op_e          buf_op;
    logic [ENT_W-1:0] rd_data;

    id_buf_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENT_W),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata ({IFPC, IFInsn}),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // Handshake and head presentation; readiness depends on registered count only.
    always_comb begin
        buf_empty  = (count_q == '0);
        bypass_act = (BYPASS != 0) && buf_empty;
        IFReady    = (count_q != CNT_W'(DEPTH));
        BufEn      = bypass_act ? IFEn : !buf_empty;
        pop        = BufEn && DecAccept && !Stall && !LDHazard && !Flush;
        push       = IFEn && IFReady && !Flush && !(pop && BrTaken);
        // A word that passes straight through to the decoder is never stored.
        wr_en      = push && !(bypass_act && pop);
        rd_adv     = pop && !bypass_act;
        buf_op     = buf_op_e'({rd_adv, wr_en});
        if (bypass_act) begin
            BufPC   = IFPC;
            BufInsn = IFInsn;
        end else if (buf_empty) begin
            // Empty stale entries are masked so an empty buffer always reads as zero.
            BufPC   = '0;
            BufInsn = '0;
        end else begin
            BufPC   = rd_data[ENT_W-1:WORD_DATA_W];
            BufInsn = rd_data[WORD_DATA_W-1:0];
        end
        BufCount   = count_q;
    end

    // Next pointer/count: flush beats branch-discard, which beats normal push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else if (pop && BrTaken) begin
            // Head consumed, every younger entry dropped; push is already suppressed.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            case (buf_op)
                BUF_OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    count_d  = count_q + CNT_W'(1);
                end
                BUF_OP_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
                BUF_OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
